counter_down_timer: RTL and testbench
=====================================

Name: counter_down_timer

Overview:
- Loadable down-counting timer; the counterpart of the free-running up counter (`counter_sync`).
- Counts down from a programmed reload value and signals the terminal count.
- Supports one-shot and auto-reload modes, with start/stop control.
- Used as a timeout or periodic-tick source next to the existing counter blocks.

Parameters:
WIDTH, 4, bit width of the count, reload register and load value (count range 0..2^WIDTH-1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous active-low reset (0 = reset asserted)
load  input  1  write load_val into the reload register
load_val  input  WIDTH  value to program
start  input  1  begin counting (sampled in IDLE/DONE only)
stop  input  1  abort counting, return to IDLE
auto_reload  input  1  1 = periodic mode, 0 = one-shot
count  output  WIDTH  current count value (registered)
busy  output  1  high while in RUN (registered)
tc  output  1  terminal-count pulse, one clk wide (registered)
done  output  1  one-shot completion flag, level (registered)

Behaviour:
- Interface fixed: one clock `clk`; `reset` is asynchronous, active-low. While reset==0: count=0, reload_reg=0, state=IDLE, busy=0, tc=0, done=0, regardless of clk.
- States are IDLE, RUN and DONE. busy=1 iff state==RUN. done=1 iff state==DONE.
- tc defaults to 0 every cycle; it is high only for the cycle after a terminal event.
- Priority per edge is stop > load/start > countdown.
- IDLE/DONE, load=1: reload_reg<=load_val and count<=load_val.
- IDLE/DONE, start=1:
  - Source value V is load_val if load=1 in the same cycle, else reload_reg.
  - If V!=0: count<=V, state<=RUN.
  - If V==0: start is ignored and state is unchanged.
  - Leaving DONE clears done.
- IDLE/DONE, stop=1: state<=IDLE, count holds. Any start in the same cycle is ignored; load is still honoured.
- RUN, stop=1: state<=IDLE, count holds its current value, no tc.
- RUN, load=1: reload_reg<=load_val only. count is unaffected; the new value takes effect at the next reload or start.
- RUN, start=1: ignored.
- RUN, count>1: count<=count-1.
- RUN, count==1 (terminal event):
  - tc<=1 in all cases.
  - auto_reload=1: count<=reload_reg (the value after any same-cycle load), state stays RUN.
  - auto_reload=0: count<=0, state<=DONE.
- Period: N = value started/reloaded. Terminal occurs N-1 edges after entering RUN with count=N, so tc pulses exactly once every N cycles in auto mode. N=1 gives tc high every cycle.
- Arithmetic: count never wraps. 0 is reachable only via one-shot completion, stop, load, or reset. Max value 2^WIDTH-1 counts a full period with no overflow.
- auto_reload is sampled only at the terminal event. It may change freely during RUN.
- Reset mid-RUN: all outputs go to 0 immediately. Counting resumes only after a fresh load+start.

Test Plan:
- Reset: hold reset=0 for 2 cycles with load=1, load_val=5 -> count=0, busy=0, tc=0, done=0 throughout; release with no start -> count stays 0.
- One-shot: load 5, then start with auto_reload=0 -> count 5,4,3,2,1,0 on consecutive edges; tc=1 exactly in the cycle count first reads 0; busy drops and done=1 that same cycle and holds.
- Auto-reload: load 3, start with auto_reload=1 -> count 3,2,1,3,2,1,...; tc pulses every 3 cycles, coincident with count returning to 3; done stays 0; stop -> IDLE, count frozen.
- Boundary values: load_val=0 + start -> stays IDLE, busy=0. load_val=15 (WIDTH=4) one-shot -> 15 down to 0, no wrap. load_val=1 auto -> tc high every cycle, count constant 1.
- Simultaneous events:
  - stop with count==1 -> no tc, IDLE, count=1.
  - load=1 + start=1 in IDLE with load_val=7 -> count=7, RUN.
  - load 9 during RUN (auto, reload 4) -> next reload value is 9.
- Async reset mid-run: assert reset=0 between clk edges while count=3 -> count, busy and tc go to 0 before the next edge; after release, start alone (reload_reg=0) is ignored.

Source files
------------

// File: rtl/counter_down_timer.sv
// Loadable down-counting timer with one-shot and auto-reload modes.
// Asserts a one-cycle terminal-count pulse each time a count runs out.
module counter_down_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] src_val;

    // A load in the same cycle takes effect for both start and reload.
    assign src_val = load ? load_val : reload_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= (state_d == RUN);
            done_q   <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            reload_d = load_val;
        end

        case (state_q)
            IDLE, DONE: begin
                if (load) begin
                    count_d = load_val;
                end
                if (stop) begin
                    state_d = IDLE;
                end else if (start && (src_val != '0)) begin
                    count_d = src_val;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (count_q <= WIDTH'(1)) begin
                    // Terminal event; a zero count is treated the same so it can never wrap.
                    tc_d = 1'b1;
                    if (auto_reload) begin
                        count_d = src_val;
                    end else begin
                        count_d = '0;
                        state_d = DONE;
                    end
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign tc    = tc_q;
    assign done  = done_q;

endmodule

// File: tb/tb_counter_down_timer.sv
// Directed-vector bench for counter_down_timer with hand-computed expectations.
module tb_counter_down_timer;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic             done;

    int n_vec;
    int n_err;

    counter_down_timer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .count       (count),
        .busy        (busy),
        .tc          (tc),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int c, input int b, input int t, input int d);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".tc"},    32'(tc),    32'(t));
        chk({tag, ".done"},  32'(done),  32'(d));
    endtask

    task automatic idle_inputs();
        load = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0; load = 1'b1; load_val = 4'd5;
        start = 1'b0; stop = 1'b0; auto_reload = 1'b0;

        // Reset held with load active
        tick(); chk_all("rst0", 0, 0, 0, 0);
        tick(); chk_all("rst1", 0, 0, 0, 0);
        #3 reset = 1'b1; load = 1'b0;
        tick(); chk_all("rst_rel", 0, 0, 0, 0);
        start = 1'b1;
        tick(); chk_all("start_zero_reload", 0, 0, 0, 0);
        idle_inputs();

        // One-shot from 5
        load = 1'b1; load_val = 4'd5;
        tick(); chk_all("os_load", 5, 0, 0, 0);
        load = 1'b0; start = 1'b1; auto_reload = 1'b0;
        tick(); chk_all("os_start", 5, 1, 0, 0);
        start = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            tick(); chk_all($sformatf("os_cnt%0d", i), i, 1, 0, 0);
        end
        tick(); chk_all("os_term", 0, 0, 1, 1);
        tick(); chk_all("os_hold", 0, 0, 0, 1);

        // Stop from DONE, then zero value start is ignored
        stop = 1'b1;
        tick(); chk_all("done_stop", 0, 0, 0, 0);
        stop = 1'b0; load = 1'b1; load_val = 4'd0; start = 1'b1;
        tick(); chk_all("zero_start", 0, 0, 0, 0);
        idle_inputs();

        // Auto-reload period 3
        load = 1'b1; load_val = 4'd3;
        tick(); chk_all("ar_load", 3, 0, 0, 0);
        load = 1'b0; start = 1'b1; auto_reload = 1'b1;
        tick(); chk_all("ar_start", 3, 1, 0, 0);
        start = 1'b0;
        for (int p = 0; p < 2; p++) begin
            tick(); chk_all($sformatf("ar_p%0d_2", p), 2, 1, 0, 0);
            tick(); chk_all($sformatf("ar_p%0d_1", p), 1, 1, 0, 0);
            tick(); chk_all($sformatf("ar_p%0d_3", p), 3, 1, 1, 0);
        end
        tick(); chk_all("ar_2", 2, 1, 0, 0);
        tick(); chk_all("ar_1", 1, 1, 0, 0);
        stop = 1'b1;
        tick(); chk_all("stop_at_1", 1, 0, 0, 0);
        stop = 1'b0;
        tick(); chk_all("stop_frozen", 1, 0, 0, 0);

        // Simultaneous load+start with 7
        load = 1'b1; load_val = 4'd7; start = 1'b1; auto_reload = 1'b0;
        tick(); chk_all("ldst7", 7, 1, 0, 0);
        idle_inputs();
        tick(); chk_all("ldst7_run", 6, 1, 0, 0);
        stop = 1'b1;
        tick(); chk_all("ldst7_stop", 6, 0, 0, 0);
        stop = 1'b0;

        // Max value one-shot, no wrap
        load = 1'b1; load_val = 4'd15; start = 1'b1;
        tick(); chk_all("max_start", 15, 1, 0, 0);
        idle_inputs();
        for (int i = 14; i >= 1; i--) begin
            tick(); chk("max_cnt", 32'(count), 32'(i));
        end
        tick(); chk_all("max_term", 0, 0, 1, 1);
        tick(); chk_all("max_hold", 0, 0, 0, 1);

        // Period 1 auto-reload: tc every cycle
        load = 1'b1; load_val = 4'd1; start = 1'b1; auto_reload = 1'b1;
        tick(); chk_all("n1_start", 1, 1, 0, 0);
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick(); chk_all($sformatf("n1_%0d", i), 1, 1, 1, 0);
        end
        stop = 1'b1;
        tick(); chk_all("n1_stop", 1, 0, 0, 0);
        stop = 1'b0;

        // Load during RUN changes the next reload value only
        load = 1'b1; load_val = 4'd4; start = 1'b1; auto_reload = 1'b1;
        tick(); chk_all("rl_start", 4, 1, 0, 0);
        idle_inputs();
        tick(); chk_all("rl_3", 3, 1, 0, 0);
        tick(); chk_all("rl_2", 2, 1, 0, 0);
        load = 1'b1; load_val = 4'd9;
        tick(); chk_all("rl_1_load", 1, 1, 0, 0);
        load = 1'b0;
        tick(); chk_all("rl_reload9", 9, 1, 1, 0);
        for (int i = 8; i >= 3; i--) begin
            tick(); chk("rl_cnt", 32'(count), 32'(i));
        end

        // Asynchronous reset between edges while count is 3
        #2 reset = 1'b0;
        #1 chk_all("async_rst", 0, 0, 0, 0);
        #2 reset = 1'b1;
        start = 1'b1;
        tick(); chk_all("post_rst_start", 0, 0, 0, 0);
        idle_inputs();
        tick(); chk_all("post_rst_idle", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
